// File: rtl/ext_pkg.sv
// Shared constants for the operand-extension pipeline: mode encodings and
// the byte-lane select width helper.
package ext_pkg;

   localparam int EXT_OP_W = 3;

   localparam logic [EXT_OP_W-1:0] EXT_SIGN = 3'd0;
   localparam logic [EXT_OP_W-1:0] EXT_ZERO = 3'd1;
   localparam logic [EXT_OP_W-1:0] EXT_LUI  = 3'd2;
   localparam logic [EXT_OP_W-1:0] EXT_LB   = 3'd3;
   localparam logic [EXT_OP_W-1:0] EXT_LBU  = 3'd4;
   localparam logic [EXT_OP_W-1:0] EXT_LH   = 3'd5;
   localparam logic [EXT_OP_W-1:0] EXT_LHU  = 3'd6;

   function automatic int off_w(input int out_w);
      return $clog2(out_w / 8);
   endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational extension function: immediate sign/zero/upper extension and
// byte/halfword load lane extraction with misalignment flag.
module ext_core
   import ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [EXT_OP_W-1:0]      op,
   input  logic [IN_W-1:0]          imm,
   input  logic [OUT_W-1:0]         word,
   input  logic [off_w(OUT_W)-1:0]  byte_off,
   output logic [OUT_W-1:0]         result,
   output logic                     misalign
);

   // Lanes running past the top of the word read as zero.
   logic [15:0] lane;
   assign lane = 16'(word >> {byte_off, 3'b000});

   always_comb begin
      result   = '0;
      misalign = 1'b0;
      case (op)
         EXT_SIGN: result = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
         EXT_ZERO: result = {{(OUT_W-IN_W){1'b0}}, imm};
         EXT_LUI:  result = {imm, {(OUT_W-IN_W){1'b0}}};
         EXT_LB:   result = {{(OUT_W-8){lane[7]}}, lane[7:0]};
         EXT_LBU:  result = {{(OUT_W-8){1'b0}}, lane[7:0]};
         EXT_LH: begin
            if (byte_off[0]) misalign = 1'b1;
            else             result   = {{(OUT_W-16){lane[15]}}, lane};
         end
         EXT_LHU: begin
            if (byte_off[0]) misalign = 1'b1;
            else             result   = {{(OUT_W-16){1'b0}}, lane};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined operand-extension unit: 1 or 2 register stages behind a
// valid/ready handshake with flush; ready chain is combinational.
module ext_pipe
   import ext_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int OUT_W  = 32,
   parameter int STAGES = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXT_OP_W-1:0]      ext_op,
   input  logic [IN_W-1:0]          imm_in,
   input  logic [OUT_W-1:0]         word_in,
   input  logic [off_w(OUT_W)-1:0]  byte_off,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         ext_out,
   output logic                     misalign
);

   localparam int OFF_W = off_w(OUT_W);
   localparam int RAW_W = (IN_W > 16) ? IN_W : 16;

   logic [EXT_OP_W-1:0] core_op;
   logic [IN_W-1:0]     core_imm;
   logic [OUT_W-1:0]    core_word;
   logic [OFF_W-1:0]    core_off;
   logic [OUT_W-1:0]    core_res;
   logic                core_mis;
   logic                src_valid;
   logic                res_ready;

   ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
      .op       (core_op),
      .imm      (core_imm),
      .word     (core_word),
      .byte_off (core_off),
      .result   (core_res),
      .misalign (core_mis)
   );

   assign res_ready = !out_valid || out_ready;

   generate
      if (STAGES == 1) begin : g_one
         assign core_op   = ext_op;
         assign core_imm  = imm_in;
         assign core_word = word_in;
         assign core_off  = byte_off;
         assign src_valid = in_valid;
         assign in_ready  = res_ready;
      end else begin : g_two
         logic                v0;
         logic [EXT_OP_W-1:0] op0;
         logic [RAW_W-1:0]    raw0;
         logic                odd0;
         logic [15:0]         lane_sel;
         logic                is_load;

         assign lane_sel  = 16'(word_in >> {byte_off, 3'b000});
         assign is_load   = ext_op inside {EXT_LB, EXT_LBU, EXT_LH, EXT_LHU};
         assign in_ready  = !v0 || res_ready;
         assign src_valid = v0;

         always_ff @(posedge clk) begin
            if (reset) begin
               v0   <= 1'b0;
               op0  <= '0;
               raw0 <= '0;
               odd0 <= 1'b0;
            end else begin
               if (flush)         v0 <= 1'b0;
               else if (in_ready) v0 <= in_valid;
               if (in_valid && in_ready && !flush) begin
                  op0  <= ext_op;
                  raw0 <= is_load ? RAW_W'(lane_sel) : RAW_W'(imm_in);
                  odd0 <= byte_off[0];
               end
            end
         end

         // Lane was pre-shifted down; re-seat it at offset 0 or 1 so the core
         // still sees the odd-offset bit for misalignment detection.
         assign core_op   = op0;
         assign core_imm  = raw0[IN_W-1:0];
         assign core_word = odd0 ? (OUT_W'(raw0[15:0]) << 8) : OUT_W'(raw0[15:0]);
         assign core_off  = OFF_W'(odd0);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         ext_out   <= '0;
         misalign  <= 1'b0;
      end else begin
         if (flush)          out_valid <= 1'b0;
         else if (res_ready) out_valid <= src_valid;
         if (src_valid && res_ready && !flush) begin
            ext_out  <= core_res;
            misalign <= core_mis;
         end
      end
   end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: one 1-stage and one 2-stage instance share
// operand inputs; each has its own handshake, expected-queue and monitor.
module tb_ext_pipe;

   typedef struct packed {
      logic [31:0] d;
      logic        m;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic [2:0]  ext_op;
   logic [15:0] imm_in;
   logic [31:0] word_in;
   logic [1:0]  byte_off;
   logic        iv1, ir1, ov1, or1, mis1;
   logic        iv2, ir2, ov2, or2, mis2;
   logic [31:0] eo1, eo2, held;

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   int   checks = 0;
   int   failures = 0;
   int   acc2 = 0;

   always #5 clk = ~clk;

   ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1)) dut1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(iv1), .in_ready(ir1),
      .ext_op(ext_op), .imm_in(imm_in), .word_in(word_in), .byte_off(byte_off),
      .out_valid(ov1), .out_ready(or1), .ext_out(eo1), .misalign(mis1)
   );

   ext_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2)) dut2 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(iv2), .in_ready(ir2),
      .ext_op(ext_op), .imm_in(imm_in), .word_in(word_in), .byte_off(byte_off),
      .out_valid(ov2), .out_ready(or2), .ext_out(eo2), .misalign(mis2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && ov1 && or1) begin
         if (q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL s1_unexpected actual=%h required=none", eo1);
         end else begin
            e1 = q1.pop_front();
            chk("s1_ext_out", eo1, e1.d);
            chk("s1_misalign", {31'b0, mis1}, {31'b0, e1.m});
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && ov2 && or2) begin
         if (q2.size() == 0) begin
            checks++; failures++;
            $display("FAIL s2_unexpected actual=%h required=none", eo2);
         end else begin
            e2 = q2.pop_front();
            chk("s2_ext_out", eo2, e2.d);
            chk("s2_misalign", {31'b0, mis2}, {31'b0, e2.m});
         end
      end
   end

   // Presents one beat to the selected instance and holds it until accepted.
   task automatic send(input bit d2, input logic [2:0] op, input logic [15:0] imm,
                       input logic [31:0] w, input logic [1:0] off,
                       input logic [31:0] ed, input logic em);
      bit done = 1'b0;
      ext_op = op; imm_in = imm; word_in = w; byte_off = off;
      if (d2) iv2 = 1'b1; else iv1 = 1'b1;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk);
         if (d2 ? ir2 : ir1) begin
            if (d2) begin q2.push_back({ed, em}); acc2++; end
            else q1.push_back({ed, em});
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      iv1 = 1'b0; iv2 = 1'b0;
      if (!done) begin
         checks++; failures++;
         $display("FAIL send_timeout actual=not_accepted required=accepted");
      end
   endtask

   localparam logic [31:0] W = 32'h80FF7F01;

   initial begin
      reset = 1'b1; flush = 1'b0; iv1 = 1'b0; iv2 = 1'b0; or1 = 1'b1; or2 = 1'b1;
      ext_op = 3'd0; imm_in = '0; word_in = '0; byte_off = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_ov1", {31'b0, ov1}, 32'd0);
      chk("rst_eo1", eo1, 32'd0);
      chk("rst_mis1", {31'b0, mis1}, 32'd0);
      chk("rst_ir1", {31'b0, ir1}, 32'd1);
      chk("rst_ov2", {31'b0, ov2}, 32'd0);
      chk("rst_eo2", eo2, 32'd0);
      chk("rst_ir2", {31'b0, ir2}, 32'd1);

      // Immediate modes, one-cycle latency
      send(0, 3'd0, 16'h8001, W, 2'd0, 32'hFFFF8001, 1'b0);
      chk("s1_lat_sign", {31'b0, ov1}, 32'd1);
      send(0, 3'd1, 16'h8001, W, 2'd0, 32'h00008001, 1'b0);
      chk("s1_lat_zero", {31'b0, ov1}, 32'd1);
      send(0, 3'd2, 16'h8001, W, 2'd0, 32'h80010000, 1'b0);
      chk("s1_lat_lui", {31'b0, ov1}, 32'd1);

      // Load modes and misalignment
      send(0, 3'd3, 16'h0000, W, 2'd2, 32'hFFFFFFFF, 1'b0);
      send(0, 3'd4, 16'h0000, W, 2'd3, 32'h00000080, 1'b0);
      send(0, 3'd5, 16'h0000, W, 2'd2, 32'hFFFF80FF, 1'b0);
      send(0, 3'd6, 16'h0000, W, 2'd0, 32'h00007F01, 1'b0);
      send(0, 3'd5, 16'h0000, W, 2'd1, 32'h00000000, 1'b1);
      send(0, 3'd0, 16'h7FFF, W, 2'd0, 32'h00007FFF, 1'b0);
      send(0, 3'd7, 16'hFFFF, W, 2'd1, 32'h00000000, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure on the 2-stage instance
      or2 = 1'b0;
      acc2 = 0;
      fork
         begin
            send(1, 3'd0, 16'h1234, W, 2'd0, 32'h00001234, 1'b0);
            send(1, 3'd1, 16'hFFFF, W, 2'd0, 32'h0000FFFF, 1'b0);
            send(1, 3'd2, 16'h00AB, W, 2'd0, 32'h00AB0000, 1'b0);
            send(1, 3'd4, 16'h0000, W, 2'd1, 32'h0000007F, 1'b0);
            send(1, 3'd5, 16'h0000, W, 2'd2, 32'hFFFF80FF, 1'b0);
         end
         begin
            repeat (3) @(posedge clk);
            #1 held = eo2;
            @(posedge clk);
            #1;
            chk("bp_in_ready_low", {31'b0, ir2}, 32'd0);
            chk("bp_accepted", acc2, 32'd2);
            chk("bp_out_valid", {31'b0, ov2}, 32'd1);
            chk("bp_hold_value", eo2, 32'h00001234);
            chk("bp_hold_stable", eo2, held);
            or2 = 1'b1;
            #1 chk("bp_in_ready_back", {31'b0, ir2}, 32'd1);
         end
      join
      repeat (4) @(posedge clk);
      #1 chk("bp_all_out", q2.size(), 32'd0);
      chk("bp_total_acc", acc2, 32'd5);

      // Odd-lane loads through the 2-stage path
      send(1, 3'd3, 16'h0000, W, 2'd3, 32'hFFFFFF80, 1'b0);
      send(1, 3'd6, 16'h0000, W, 2'd3, 32'h00000000, 1'b1);
      send(1, 3'd5, 16'h0000, W, 2'd0, 32'h00007F01, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Flush with pipe full and a same-cycle beat
      or2 = 1'b0;
      send(1, 3'd0, 16'h1111, W, 2'd0, 32'h00001111, 1'b0);
      send(1, 3'd0, 16'h2222, W, 2'd0, 32'h00002222, 1'b0);
      ext_op = 3'd0; imm_in = 16'h3333; iv2 = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0; iv2 = 1'b0;
      q2.delete();
      chk("flush_ov2", {31'b0, ov2}, 32'd0);
      or2 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      // Flush while in_ready is high on an empty pipe
      ext_op = 3'd1; imm_in = 16'h4444; iv2 = 1'b1; flush = 1'b1;
      chk("flush_ir_ungated", {31'b0, ir2}, 32'd1);
      @(posedge clk);
      #1 flush = 1'b0; iv2 = 1'b0;
      chk("flush2_ov2_n1", {31'b0, ov2}, 32'd0);
      @(posedge clk);
      #1 chk("flush2_ov2_n2", {31'b0, ov2}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      send(1, 3'd1, 16'h8001, W, 2'd0, 32'h00008001, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-stream with outputs stalled
      or1 = 1'b0; or2 = 1'b0;
      send(0, 3'd5, 16'h0000, W, 2'd1, 32'h00000000, 1'b1);
      send(1, 3'd0, 16'h8001, W, 2'd0, 32'hFFFF8001, 1'b0);
      send(1, 3'd1, 16'h8001, W, 2'd0, 32'h00008001, 1'b0);
      chk("pre_rst_ir2", {31'b0, ir2}, 32'd0);
      chk("pre_rst_mis1", {31'b0, mis1}, 32'd1);
      chk("pre_rst_eo2", eo2, 32'hFFFF8001);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_ov1", {31'b0, ov1}, 32'd0);
      chk("mrst_mis1", {31'b0, mis1}, 32'd0);
      chk("mrst_ov2", {31'b0, ov2}, 32'd0);
      chk("mrst_eo2", eo2, 32'd0);
      chk("mrst_mis2", {31'b0, mis2}, 32'd0);
      q1.delete(); q2.delete();
      reset = 1'b0;
      #1;
      chk("mrst_ir1", {31'b0, ir1}, 32'd1);
      chk("mrst_ir2", {31'b0, ir2}, 32'd1);
      or1 = 1'b1; or2 = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("end_q1_empty", q1.size(), 32'd0);
      chk("end_q2_empty", q2.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
